// File: rtl/async_event_arbiter.sv
// Asynchronous event front end: per-channel synchronizer, edge capture and round-robin valid/ready delivery.
// Define ASYNC_EVT_BOTH_EDGES_EN to treat falling edges as events and report their polarity on evt_edge.
module async_event_arbiter #(
    parameter int CHANNELS    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int ID_W        = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [CHANNELS-1:0] async_in,
    output logic                evt_valid,
    input  logic                evt_ready,
    output logic [ID_W-1:0]     evt_id,
    output logic                evt_edge,
    output logic [CHANNELS-1:0] pending,
    output logic [CHANNELS-1:0] overrun,
    input  logic [CHANNELS-1:0] overrun_clr
);

    typedef enum logic {IDLE, PRESENT} state_t;

    state_t              state, state_nxt;
    logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
    logic [CHANNELS-1:0] s_d;
    logic [CHANNELS-1:0] rise;
    logic [CHANNELS-1:0] evt_det;
    logic [CHANNELS-1:0] clr_vec;
    logic [ID_W-1:0]     last;
    logic [ID_W-1:0]     grant_id;
    logic                grant_found;
    logic                grant_pol;
    logic                accept;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
            s_d <= '0;
        end else begin
            sync_q[0] <= async_in;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
            s_d <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~s_d;

`ifdef ASYNC_EVT_BOTH_EDGES_EN
    logic [CHANNELS-1:0] pol;

    assign evt_det = rise | (~sync_q[SYNC_STAGES-1] & s_d);

    // Latest edge polarity wins, including when it coalesces into a pending event.
    always_ff @(posedge clock) begin
        pol <= (pol & ~evt_det) | (rise & evt_det);
    end

    assign grant_pol = pol[grant_id];
`else
    assign evt_det   = rise;
    assign grant_pol = 1'b1;
`endif

    assign accept = evt_valid & evt_ready;

    always_comb begin
        clr_vec = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            clr_vec[i] = accept && (evt_id == ID_W'(i));
        end
    end

    // A new edge beats a same-cycle accept; only an uncleared pending bit counts as overrun.
    always_ff @(posedge clock) begin
        if (reset) begin
            pending <= '0;
            overrun <= '0;
        end else begin
            pending <= evt_det | (pending & ~clr_vec);
            overrun <= (evt_det & pending & ~clr_vec) | (overrun & ~overrun_clr);
        end
    end

    // Round-robin search starting just above the last accepted channel.
    always_comb begin
        int idx;
        idx         = 0;
        grant_id    = '0;
        grant_found = 1'b0;
        for (int k = 1; k <= CHANNELS; k++) begin
            idx = int'(last) + k;
            if (idx >= CHANNELS) idx = idx - CHANNELS;
            if (!grant_found && pending[ID_W'(idx)]) begin
                grant_found = 1'b1;
                grant_id    = ID_W'(idx);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|pending) state_nxt = PRESENT;
            PRESENT: if (evt_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        evt_valid = (state == PRESENT);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            evt_id   <= '0;
            evt_edge <= 1'b0;
            last     <= ID_W'(CHANNELS - 1);
        end else begin
            if (state == IDLE && grant_found) begin
                evt_id   <= grant_id;
                evt_edge <= grant_pol;
            end
            if (accept) last <= evt_id;
        end
    end

endmodule

// File: tb/tb_async_event_arbiter.sv
// Directed bench for async_event_arbiter: single event, round-robin, back-pressure, overrun, reset and optional both-edge mode.
module tb_async_event_arbiter;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] async_in;
    logic       evt_valid;
    logic       evt_ready;
    logic [1:0] evt_id;
    logic       evt_edge;
    logic [3:0] pending;
    logic [3:0] overrun;
    logic [3:0] overrun_clr;

    int n_checks = 0;
    int n_errors = 0;

    logic [1:0] gid_q [$];
    logic       gedge_q [$];

    async_event_arbiter #(.CHANNELS(4), .SYNC_STAGES(2), .ID_W(2)) dut (
        .clock       (clock),
        .reset       (reset),
        .async_in    (async_in),
        .evt_valid   (evt_valid),
        .evt_ready   (evt_ready),
        .evt_id      (evt_id),
        .evt_edge    (evt_edge),
        .pending     (pending),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_reset();
        async_in    = '0;
        overrun_clr = '0;
        evt_ready   = 1'b0;
        reset       = 1'b1;
        tick(2);
        reset = 1'b0;
    endtask

    // Records every presented event; only meaningful while evt_ready is held high.
    task automatic collect(input int n);
        gid_q.delete();
        gedge_q.delete();
        for (int k = 0; k < n; k++) begin
            tick(1);
            if (evt_valid) begin
                gid_q.push_back(evt_id);
                gedge_q.push_back(evt_edge);
            end
        end
    endtask

    task automatic check_rr(input string tag);
        logic [1:0] exp_rr [3];
        exp_rr = '{2'd0, 2'd1, 2'd3};
        check({tag, "_count"}, 32'(gid_q.size()), 32'd3);
        for (int k = 0; k < 3 && k < gid_q.size(); k++) begin
            check($sformatf("%s_grant%0d", tag, k), 32'(gid_q[k]), 32'(exp_rr[k]));
        end
    endtask

    initial begin
        int bad;

        async_in    = '0;
        overrun_clr = '0;
        evt_ready   = 1'b0;
        reset       = 1'b0;

        // Reset values
        do_reset();
        check("rst_valid", 32'(evt_valid), 32'd0);
        check("rst_id", 32'(evt_id), 32'd0);
        check("rst_edge", 32'(evt_edge), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);

        // Single event on channel 2
        async_in = 4'b0100;
        tick(2);
        check("single_pend_early", 32'(pending), 32'h0);
        tick(1);
        check("single_pend", 32'(pending), 32'h4);
        check("single_valid_early", 32'(evt_valid), 32'd0);
        tick(1);
        check("single_valid", 32'(evt_valid), 32'd1);
        check("single_id", 32'(evt_id), 32'd2);
        check("single_edge", 32'(evt_edge), 32'd1);
        evt_ready = 1'b1;
        tick(1);
        check("single_acc_valid", 32'(evt_valid), 32'd0);
        check("single_acc_pend", 32'(pending), 32'h0);
        evt_ready = 1'b0;
`ifndef ASYNC_EVT_BOTH_EDGES_EN
        async_in = 4'b0000;
        tick(5);
        check("no_fall_pend", 32'(pending), 32'h0);
        check("no_fall_valid", 32'(evt_valid), 32'd0);
`endif

        // Round-robin fairness, twice
        do_reset();
        evt_ready = 1'b1;
        async_in  = 4'b1011;
        collect(14);
        check_rr("rr1");
        async_in = 4'b0000;
        tick(12);
        async_in = 4'b1011;
        collect(14);
        check_rr("rr2");

        // Back-pressure holds the presented event
        do_reset();
        async_in = 4'b0010;
        tick(4);
        check("bp_valid", 32'(evt_valid), 32'd1);
        check("bp_id", 32'(evt_id), 32'd1);
        async_in = 4'b0011;
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            tick(1);
            if (!(evt_valid === 1'b1 && evt_id === 2'd1)) bad++;
        end
        check("bp_hold_bad_cycles", 32'(bad), 32'd0);
        check("bp_pend", 32'(pending), 32'h3);
        evt_ready = 1'b1;
        tick(1);
        check("bp_acc_valid", 32'(evt_valid), 32'd0);
        check("bp_acc_pend", 32'(pending), 32'h1);
        tick(1);
        check("bp_next_valid", 32'(evt_valid), 32'd1);
        check("bp_next_id", 32'(evt_id), 32'd0);
        evt_ready = 1'b0;

        // Overrun, clear, and set-wins-over-clear
        do_reset();
        async_in = 4'b1000;
        tick(4);
        check("ovr_valid", 32'(evt_valid), 32'd1);
        check("ovr_id", 32'(evt_id), 32'd3);
        async_in = 4'b0000;
        tick(3);
        async_in = 4'b1000;
        tick(3);
        check("ovr_set", 32'(overrun), 32'h8);
        check("ovr_pend", 32'(pending), 32'h8);
        overrun_clr = 4'b1000;
        tick(1);
        overrun_clr = 4'b0000;
        check("ovr_clr", 32'(overrun), 32'h0);
        async_in = 4'b0000;
        tick(3);
        async_in = 4'b1000;
        tick(2);
        overrun_clr = 4'b1000;
        tick(1);
        overrun_clr = 4'b0000;
        check("ovr_set_wins", 32'(overrun), 32'h8);
        evt_ready = 1'b1;
        tick(1);
        check("ovr_acc_valid", 32'(evt_valid), 32'd0);
        check("ovr_acc_pend", 32'(pending), 32'h0);
        bad = 0;
        for (int k = 0; k < 6; k++) begin
            tick(1);
            if (evt_valid) bad++;
        end
        check("ovr_single_delivery", 32'(bad), 32'd0);
        evt_ready = 1'b0;

        // Reset while presenting; next grant restarts from channel 0
        do_reset();
        evt_ready = 1'b1;
        async_in  = 4'b0010;
        tick(5);
        check("mid_pre_acc", 32'(evt_valid), 32'd0);
        async_in = 4'b0000;
        tick(6);
        evt_ready = 1'b0;
        async_in  = 4'b1011;
        tick(4);
        check("mid_valid", 32'(evt_valid), 32'd1);
        check("mid_id_from_last1", 32'(evt_id), 32'd3);
        check("mid_pend", 32'(pending), 32'hb);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("mid_rst_valid", 32'(evt_valid), 32'd0);
        check("mid_rst_pend", 32'(pending), 32'h0);
        tick(4);
        check("mid_regrant_valid", 32'(evt_valid), 32'd1);
        check("mid_regrant_id", 32'(evt_id), 32'd0);

`ifdef ASYNC_EVT_BOTH_EDGES_EN
        // High-then-low pulse yields a rising then a falling event
        do_reset();
        evt_ready = 1'b1;
        async_in  = 4'b0001;
        tick(4);
        async_in = 4'b0000;
        collect(12);
        // The rising event was already presented inside the first four cycles.
        check("both_fall_count", 32'(gid_q.size()), 32'd1);
        if (gid_q.size() >= 1) begin
            check("both_fall_id", 32'(gid_q[0]), 32'd0);
            check("both_fall_edge", 32'(gedge_q[0]), 32'd0);
        end
        do_reset();
        evt_ready = 1'b1;
        async_in  = 4'b0001;
        collect(4);
        async_in = 4'b0000;
        tick(2);
        check("both_rise_count", 32'(gid_q.size()), 32'd1);
        if (gid_q.size() >= 1) begin
            check("both_rise_id", 32'(gid_q[0]), 32'd0);
            check("both_rise_edge", 32'(gedge_q[0]), 32'd1);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/async_event_arbiter.md
# async_event_arbiter

Multi-channel front end for asynchronous event inputs. Each channel synchronizes its input into the `clock` domain and detects edges. Each detected edge is latched as a pending event. The block then presents pending events one at a time to a single downstream consumer over a valid/ready handshake, with round-robin fairness and per-channel overrun reporting. It sits between raw asynchronous pins or foreign-domain strobes and the synchronous control logic that services them.

## Interface
Parameters:
- `CHANNELS`, default 4: number of asynchronous inputs. Legal range is 2–16.
- `SYNC_STAGES`, default 2: synchronizer depth. Minimum 2.
- `ID_W`, default 2: width of `evt_id`. Must equal ceil(log2(`CHANNELS`)).

Ports:
- `clock`, input, 1: system clock. All state is on its rising edge.
- `reset`, input, 1: reset, synchronous, active-high. Clock `clock`.
- `async_in`, input, `CHANNELS`: asynchronous event lines, one per channel.
- `evt_valid`, output, 1: an event is presented on `evt_id` / `evt_edge`.
- `evt_ready`, input, 1: the consumer accepts the presented event.
- `evt_id`, output, `ID_W`: channel index of the presented event.
- `evt_edge`, output, 1: polarity of the presented event. 1 means rising, 0 means falling.
- `pending`, output, `CHANNELS`: per-channel pending-event flags.
- `overrun`, output, `CHANNELS`: sticky per-channel flag meaning an event was coalesced.
- `overrun_clr`, input, `CHANNELS`: write-1-to-clear for `overrun`. Acts as a single-cycle strobe.

## Operation
- **Synchronizer:** each channel has a `SYNC_STAGES`-deep flop chain plus one history flop `s_d`. All of these reset to 0.
- **Edge detect:** rising edge is `s & ~s_d`, where `s` is the last synchronizer stage.
- **`pending` set/clear:**
  - A detected edge sets `pending[i]`.
  - An accepted event (`evt_valid & evt_ready`, with `evt_id == i`) clears `pending[i]`.
  - If a new edge and an accept of the same channel occur in the same cycle, `pending[i]` stays 1. This is a new event, not an overrun.
- **Overrun:**
  - An edge on a channel whose `pending[i]` is already 1, and is not being cleared that cycle, coalesces into the existing event and sets `overrun[i]`.
  - `overrun_clr[i]` clears `overrun[i]`.
  - A set and a clear in the same cycle leave `overrun[i]` = 1; set wins.
- **Output FSM, state IDLE:**
  - If any `pending` bit is 1, select the first set bit searching upward (with wrap-around) from `last+1`.
  - Register the selection into `evt_id` / `evt_edge`, assert `evt_valid`, and go to PRESENT.
  - If no `pending` bit is set, stay in IDLE.
- **Output FSM, state PRESENT:**
  - `evt_valid` = 1, and `evt_id` / `evt_edge` are held stable until accepted.
  - On `evt_ready`, clear the granted channel's `pending` bit, set `last` = `evt_id`, deassert `evt_valid`, and return to IDLE.
- **Fairness:** `last` resets to `CHANNELS-1`, so the first grant after reset searches from channel 0. A channel that is continuously pending is granted at least once every `CHANNELS` accepts.
- **Handshake:** `evt_ready` while `evt_valid` = 0 is ignored. The consumer may hold `evt_ready` high permanently.
- **Reset:** all outputs are 0 and the FSM is in IDLE. `evt_id` = 0, `evt_edge` = 0, and `last` = `CHANNELS-1`. Reset asserted mid-PRESENT drops the presented event and clears every pending event.

## Timing
- **Capture to pending:** let E0 be the first rising edge of `clock` that samples `async_in[i]` high. Then:
  - the last synchronizer stage is high after E(`SYNC_STAGES`-1);
  - `pending[i]` is high after E(`SYNC_STAGES`).
- **Pending to valid:** `evt_valid` is high after E(`SYNC_STAGES`+1), provided the FSM was idle. With default parameters that is 3 cycles after E0.
- **Throughput:** a single-cycle bubble in IDLE after each accept gives a peak of 1 event per 2 cycles.
- **Input pulse width:** an `async_in` level must be held for at least one `clock` period plus setup to be guaranteed captured. Shorter pulses may be lost; this is not flagged.
- **Overrun flag:** `overrun[i]` rises in the same cycle as the coalesced edge would have set `pending[i]`.

## Configuration
- **`ASYNC_EVT_BOTH_EDGES_EN` defined:**
  - Falling edges (`~s & s_d`) are also events.
  - A per-channel polarity flop records the polarity of the latest edge. On a coalesce, the latest edge's polarity overwrites the stored one.
  - `evt_edge` reports the stored polarity.
- **`ASYNC_EVT_BOTH_EDGES_EN` not defined:**
  - Only rising edges generate events.
  - `evt_edge` is constant 1 whenever `evt_valid` is 1.
  - No polarity flops are built.

## Test plan
- **Single event:** reset, then raise `async_in[2]` and hold it. Required response: `pending[2]`=1 after 2 cycles, `evt_valid`=1 with `evt_id`=2 and `evt_edge`=1 after 3 cycles. Accepting with `evt_ready`=1 clears `pending[2]`, and `evt_valid` is 0 on the next cycle.
- **Round-robin fairness:** raise channels 0, 1 and 3 simultaneously with `evt_ready`=1. Required grant order is 0, 1, 3. Retrigger all three and the order is again 0, 1, 3. No channel is granted twice before the others.
- **Back-pressure:** with `evt_ready`=0 for 10 cycles and channel 1 presented, then raise channel 0. Required response: `evt_id` stays 1 and `evt_valid` stays 1 throughout. Channel 0 is granted only after channel 1 is accepted.
- **Overrun and clear:** with channel 3 pending and `evt_ready`=0, toggle `async_in[3]` low then high (≥2 cycles each). Required response: `overrun[3]`=1 and only one event is delivered for channel 3. Pulse `overrun_clr[3]` and `overrun[3]` returns to 0. Pulse `overrun_clr[3]` in the same cycle as a new coalesce and `overrun[3]` stays 1.
- **Reset mid-operation:** assert `reset` for 1 cycle while in PRESENT with `pending`=4'b1011. Required response: the next cycle shows `evt_valid`=0 and `pending`=0, and the next grant starts from channel 0.
- **Both edges (macro defined):** a high-then-low pulse of 4 cycles on channel 0 with `evt_ready`=1. Required response: two events with `evt_id`=0, the first with `evt_edge`=1 and the second with `evt_edge`=0.
